// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state type, default taps and LFSR/parity helpers.
package lfsr_pkg;
   typedef enum logic {IDLE, RUN} lfsr_state_e;
   localparam logic [6:0] TAPS_W7 = 7'b110_0000;
   // Operands are zero-extended to 32 bits; callers truncate the result to their width.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
      return {s[30:0], ^(s & taps)};
   endfunction
   function automatic logic lfsr_parity(input logic [31:0] s, input logic par_sel);
      return par_sel ? ^s : ~^s;
   endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: combinational Fibonacci LFSR step and selectable parity.
module lfsr_core import lfsr_pkg::*; #(
   parameter int WIDTH = 7,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_W7)
) (
   input  logic [WIDTH-1:0] state_i,
   input  logic             par_sel_i,
   output logic [WIDTH-1:0] next_state_o,
   output logic             parity_o
);
   assign next_state_o = WIDTH'(lfsr_next(32'(state_i), 32'(TAPS)));
   assign parity_o     = lfsr_parity(32'(state_i), par_sel_i);
endmodule

// File: rtl/lfsr_parity_stream.sv
// lfsr_parity_stream: LFSR pattern source with parity, valid/ready stream,
// seed loading with all-zero recovery, and period measurement.
module lfsr_parity_stream import lfsr_pkg::*; #(
   parameter int WIDTH = 7,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_W7),
   parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             par_sel,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH:0]   out_data,
   output logic             lockup_err,
   output logic             period_done,
   output logic [WIDTH-1:0] period_len
);
   lfsr_state_e      fsm_q, fsm_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d, start_q, start_d, cnt_q, cnt_d, len_q, len_d;
   logic             lockup_q, lockup_d, done_q, done_d;
   logic [WIDTH-1:0] nxt, seed_val;
   logic             parity, idle_load, xfer, hit;

   lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
      .state_i      (lfsr_q),
      .par_sel_i    (par_sel),
      .next_state_o (nxt),
      .parity_o     (parity)
   );

   assign out_valid   = fsm_q == RUN;
   assign out_data    = {parity, lfsr_q};
   assign lockup_err  = lockup_q;
   assign period_done = done_q;
   assign period_len  = len_q;
   assign idle_load   = fsm_q == IDLE && load;
   // An all-zero seed would lock the LFSR, so SEED is substituted.
   assign seed_val    = seed_in == '0 ? SEED : seed_in;
   assign xfer        = out_valid && out_ready;
   assign hit         = nxt == start_q;

   always_comb begin
      fsm_d    = fsm_q == IDLE ? (en ? RUN : IDLE) : (xfer && !en ? IDLE : RUN);
      lfsr_d   = idle_load ? seed_val : (xfer ? nxt : lfsr_q);
      start_d  = idle_load ? seed_val : start_q;
      cnt_d    = idle_load ? '0 : (xfer ? (hit ? '0 : cnt_q + 1'b1) : cnt_q);
      len_d    = xfer && hit ? cnt_q + 1'b1 : len_q;
      done_d   = xfer && hit;
      lockup_d = idle_load && seed_in == '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q    <= IDLE;
         lfsr_q   <= SEED;
         start_q  <= SEED;
         cnt_q    <= '0;
         len_q    <= '0;
         lockup_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         lfsr_q   <= lfsr_d;
         start_q  <= start_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         lockup_q <= lockup_d;
         done_q   <= done_d;
      end
   end
endmodule

// File: tb/tb_lfsr_parity_stream.sv
// tb_lfsr_parity_stream: directed checks of the 7-bit LFSR stream against hand-computed words.
module tb_lfsr_parity_stream;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, par_sel = 1'b0, out_ready = 1'b0;
   logic [6:0] seed_in = '0;
   logic       out_valid, lockup_err, period_done;
   logic [7:0] out_data;
   logic [6:0] period_len;
   int         total = 0, bad = 0;

   lfsr_parity_stream dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .par_sel(par_sel),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .lockup_err(lockup_err), .period_done(period_done), .period_len(period_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'hC1, 8'h83};
      int n;
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 8'h01);
      chk("rst_lockup", lockup_err, 0);
      chk("rst_done", period_done, 0);
      chk("rst_len", period_len, 0);
      en = 1'b1;
      out_ready = 1'b1;
      #1 chk("valid_before_edge", out_valid, 0);
      step();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("seq_valid%0d", i), out_valid, 1);
         chk($sformatf("seq_data%0d", i), out_data, seq[i]);
         step();
      end
      chk("after8", out_data, 8'h86);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_valid%0d", i), out_valid, 1);
         chk($sformatf("bp_data%0d", i), out_data, 8'h86);
      end
      out_ready = 1'b1;
      step();
      chk("bp_resume", out_data, 8'h8C);
      n = 9;
      while (n < 300) begin
         step();
         n++;
         if (period_done) break;
      end
      chk("period_xfers", n, 127);
      chk("period_len", period_len, 127);
      chk("period_wrap", out_data, 8'h01);
      step();
      chk("done_once", period_done, 0);
      chk("post_wrap", out_data, 8'h02);
      out_ready = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("drop_hold%0d", i), out_valid, 1);
         chk($sformatf("drop_data%0d", i), out_data, 8'h02);
      end
      out_ready = 1'b1;
      step();
      chk("drop_idle", out_valid, 0);
      chk("drop_adv", out_data, 8'h04);
      step();
      chk("idle_stable", out_data, 8'h04);
      load = 1'b1;
      seed_in = 7'h00;
      step();
      load = 1'b0;
      chk("lockup_pulse", lockup_err, 1);
      chk("lockup_seed", out_data, 8'h01);
      step();
      chk("lockup_clear", lockup_err, 0);
      en = 1'b1;
      step();
      chk("lk_seq0", out_data, 8'h01);
      step();
      chk("lk_seq1", out_data, 8'h02);
      step();
      chk("lk_seq2", out_data, 8'h04);
      en = 1'b0;
      step();
      chk("lk_stop_valid", out_valid, 0);
      chk("lk_stop_data", out_data, 8'h08);
      load = 1'b1;
      seed_in = 7'h55;
      par_sel = 1'b1;
      en = 1'b1;
      step();
      seed_in = 7'h11;
      chk("ld55_valid", out_valid, 1);
      chk("ld55_data", out_data, 8'h55);
      chk("ld55_nolock", lockup_err, 0);
      step();
      chk("run_load_ign", out_data, 8'h2B);
      step();
      chk("xor_parity", out_data, 8'hD7);
      chk("len_kept", period_len, 127);
      load = 1'b0;
      rst = 1'b1;
      #2;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 8'h81);
      chk("arst_len", period_len, 0);
      chk("arst_lockup", lockup_err, 0);
      chk("arst_done", period_done, 0);
      step();
      rst = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
